// File: rtl/regfile_mp_if.sv
// Register file port bundle: read addresses/data/busy, write, alloc and busy count.
// The master side (decode/writeback) drives requests; the slave side (register file) returns registered results.
// No handshake: every field is sampled on each rising clock edge.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2
);
  logic [NREAD*ADDR_W-1:0] rd_addr;
  logic [NREAD*DATA_W-1:0] rd_data;
  logic [NREAD-1:0]        rd_busy;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic                    alloc_en;
  logic [ADDR_W-1:0]       alloc_addr;
  logic [ADDR_W:0]         busy_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    input  rd_data, rd_busy, busy_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    output rd_data, rd_busy, busy_cnt
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with per-register busy scoreboard and busy counter.
// Latency: reads registered, 1 cycle; writes/allocs take effect at the edge.
// Backpressure: none, every port accepts a request every cycle.
module regfile_mp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NREAD   = 2,
  parameter bit BYPASS  = 1'b0,
  parameter bit ZERO_R0 = 1'b1
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0]       mem [DEPTH];
  logic [DEPTH-1:0]        busy;
  logic [DEPTH-1:0]        busy_nxt;
  logic [CNT_W-1:0]        cnt;
  logic                    wr_ok;
  logic                    alloc_ok;
  logic                    cnt_inc;
  logic                    cnt_dec;
  logic [ADDR_W-1:0]       ra;
  logic [NREAD*DATA_W-1:0] rd_data_q;
  logic [NREAD*DATA_W-1:0] rd_data_nxt;
  logic [NREAD-1:0]        rd_busy_q;
  logic [NREAD-1:0]        rd_busy_nxt;

  // Qualify write/alloc: register 0 is immutable when it is hardwired to zero.
  always_comb begin
    wr_ok    = bus.wr_en    && !(ZERO_R0 && (bus.wr_addr    == '0));
    alloc_ok = bus.alloc_en && !(ZERO_R0 && (bus.alloc_addr == '0));
  end

  // Next busy vector: write clears, alloc sets, alloc applied last so it wins on the same address.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok) begin
      busy_nxt[bus.wr_addr] = 1'b0;
    end
    if (alloc_ok) begin
      busy_nxt[bus.alloc_addr] = 1'b1;
    end
  end

  // Counter deltas track only real 0->1 and 1->0 transitions, so the count equals popcount(busy).
  always_comb begin
    cnt_inc = alloc_ok && !busy[bus.alloc_addr];
    cnt_dec = wr_ok && busy[bus.wr_addr] &&
              !(alloc_ok && (bus.alloc_addr == bus.wr_addr));
  end

  // Per-port read selection: array lookup, optional same-cycle write forwarding, zero register override.
  always_comb begin
    ra          = '0;
    rd_data_nxt = '0;
    rd_busy_nxt = '0;
    for (int i = 0; i < NREAD; i++) begin
      ra = bus.rd_addr[i*ADDR_W +: ADDR_W];
      rd_data_nxt[i*DATA_W +: DATA_W] = mem[ra];
      rd_busy_nxt[i]                  = busy[ra];
      // A same-cycle alloc is deliberately not forwarded; only the write is.
      if (BYPASS && wr_ok && (bus.wr_addr == ra)) begin
        rd_data_nxt[i*DATA_W +: DATA_W] = bus.wr_data;
        rd_busy_nxt[i]                  = 1'b0;
      end
      if (ZERO_R0 && (ra == '0)) begin
        rd_data_nxt[i*DATA_W +: DATA_W] = '0;
        rd_busy_nxt[i]                  = 1'b0;
      end
    end
  end

  // Architectural state: register array, busy bits and busy counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
      busy <= '0;
      cnt  <= '0;
    end else begin
      if (wr_ok) begin
        mem[bus.wr_addr] <= bus.wr_data;
      end
      busy <= busy_nxt;
      cnt  <= cnt + {{ADDR_W{1'b0}}, cnt_inc} - {{ADDR_W{1'b0}}, cnt_dec};
    end
  end

  // Registered read outputs, using pre-edge state (plus forwarding when enabled).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      rd_data_q <= rd_data_nxt;
      rd_busy_q <= rd_busy_nxt;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_busy  = rd_busy_q;
  assign bus.busy_cnt = cnt;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one instance without bypass (u0), one with bypass (u1),
// both driven by identical stimulus so read-timing differences can be compared directly.
module tb_regfile_mp;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) bus0 ();
  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) bus1 ();

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .BYPASS(1'b0), .ZERO_R0(1'b1))
    u0 (.clk(clk), .rst(rst), .bus(bus0));
  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .BYPASS(1'b1), .ZERO_R0(1'b1))
    u1 (.clk(clk), .rst(rst), .bus(bus1));

  // Mirror the request side of bus0 onto bus1.
  assign bus1.rd_addr    = bus0.rd_addr;
  assign bus1.wr_en      = bus0.wr_en;
  assign bus1.wr_addr    = bus0.wr_addr;
  assign bus1.wr_data    = bus0.wr_data;
  assign bus1.alloc_en   = bus0.alloc_en;
  assign bus1.alloc_addr = bus0.alloc_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    bus0.rd_addr = {a1, a0};
  endtask

  task automatic do_wr(input logic en, input logic [4:0] a, input logic [31:0] d);
    bus0.wr_en   = en;
    bus0.wr_addr = a;
    bus0.wr_data = d;
  endtask

  task automatic do_alloc(input logic en, input logic [4:0] a);
    bus0.alloc_en   = en;
    bus0.alloc_addr = a;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_u0_data"}, bus0.rd_data, 64'h0);
    chk({tag, "_u0_busy"}, bus0.rd_busy, 64'h0);
    chk({tag, "_u0_cnt"},  bus0.busy_cnt, 64'h0);
    chk({tag, "_u1_data"}, bus1.rd_data, 64'h0);
    chk({tag, "_u1_busy"}, bus1.rd_busy, 64'h0);
    chk({tag, "_u1_cnt"},  bus1.busy_cnt, 64'h0);
  endtask

  initial begin
    rst = 1'b1;
    set_rd(5'd0, 5'd0);
    do_wr(1'b0, 5'd0, 32'h0);
    do_alloc(1'b0, 5'd0);
    #1;
    chk_zero("reset_initial");
    step;
    step;
    rst = 1'b0;

    // Reset with traffic in flight.
    do_wr(1'b1, 5'd5, 32'hDEADBEEF);
    do_alloc(1'b1, 5'd6);
    set_rd(5'd5, 5'd6);
    step;
    chk("traffic_cnt", bus0.busy_cnt, 64'd1);
    chk("traffic_u0_old", bus0.rd_data[31:0], 64'h0);
    chk("traffic_u1_byp", bus1.rd_data[31:0], 64'hDEADBEEF);
    do_wr(1'b0, 5'd0, 32'h0);
    do_alloc(1'b0, 5'd0);
    step;
    chk("traffic_rd5", bus0.rd_data[31:0], 64'hDEADBEEF);
    chk("traffic_busy6", bus0.rd_busy[1], 64'd1);
    #3;
    rst = 1'b1;
    #1;
    chk_zero("reset_async");
    #2;
    rst = 1'b0;
    step;
    chk_zero("reset_after");

    // Basic read/write, with r3 allocated first so the busy forwarding is visible.
    do_alloc(1'b1, 5'd3);
    step;
    chk("basic_alloc_cnt", bus0.busy_cnt, 64'd1);
    do_alloc(1'b0, 5'd0);
    do_wr(1'b1, 5'd3, 32'h12345678);
    set_rd(5'd3, 5'd3);
    step;
    chk("basic_u0_old_data", bus0.rd_data[31:0], 64'h0);
    chk("basic_u0_old_busy", bus0.rd_busy[0], 64'd1);
    chk("basic_u1_byp_data", bus1.rd_data[31:0], 64'h12345678);
    chk("basic_u1_byp_busy", bus1.rd_busy[0], 64'd0);
    chk("basic_cnt", bus0.busy_cnt, 64'd0);
    do_wr(1'b0, 5'd0, 32'h0);
    step;
    chk("basic_u0_p0", bus0.rd_data[31:0], 64'h12345678);
    chk("basic_u0_p1", bus0.rd_data[63:32], 64'h12345678);
    chk("basic_u0_busy", bus0.rd_busy, 64'd0);
    chk("basic_u1_p1", bus1.rd_data[63:32], 64'h12345678);

    // Zero register: writes and allocs ignored, even with bypass.
    do_wr(1'b1, 5'd0, 32'hFFFFFFFF);
    do_alloc(1'b1, 5'd0);
    set_rd(5'd0, 5'd0);
    step;
    chk_zero("zero_same");
    do_wr(1'b0, 5'd0, 32'h0);
    do_alloc(1'b0, 5'd0);
    step;
    chk_zero("zero_next");

    // Scoreboard sequence.
    set_rd(5'd0, 5'd1);
    do_alloc(1'b1, 5'd1);
    step;
    chk("sb_cnt1", bus0.busy_cnt, 64'd1);
    chk("sb_alloc_not_fwd", bus1.rd_busy[1], 64'd0);
    do_alloc(1'b1, 5'd2);
    step;
    chk("sb_cnt2", bus0.busy_cnt, 64'd2);
    chk("sb_r1_busy", bus0.rd_busy[1], 64'd1);
    do_alloc(1'b1, 5'd3);
    step;
    chk("sb_cnt3", bus0.busy_cnt, 64'd3);
    do_alloc(1'b1, 5'd2);
    step;
    chk("sb_realloc_cnt", bus0.busy_cnt, 64'd3);
    do_wr(1'b1, 5'd1, 32'h11);
    do_alloc(1'b1, 5'd4);
    step;
    chk("sb_wr1_alloc4_cnt", bus0.busy_cnt, 64'd3);
    chk("sb_wr1_alloc4_u1cnt", bus1.busy_cnt, 64'd3);
    do_wr(1'b1, 5'd2, 32'h22);
    do_alloc(1'b1, 5'd2);
    set_rd(5'd2, 5'd1);
    step;
    chk("sb_same_cnt", bus0.busy_cnt, 64'd3);
    chk("sb_same_u0_busy", bus0.rd_busy[0], 64'd1);
    chk("sb_same_u1_busy", bus1.rd_busy[0], 64'd0);
    chk("sb_same_u1_data", bus1.rd_data[31:0], 64'h22);
    chk("sb_r1_data", bus0.rd_data[63:32], 64'h11);
    chk("sb_r1_cleared", bus0.rd_busy[1], 64'd0);
    do_alloc(1'b0, 5'd0);
    do_wr(1'b1, 5'd3, 32'h33);
    step;
    chk("sb_same_r2_busy", bus0.rd_busy[0], 64'd1);
    chk("sb_same_r2_data", bus0.rd_data[31:0], 64'h22);
    chk("sb_wr3_cnt", bus0.busy_cnt, 64'd2);
    do_wr(1'b1, 5'd4, 32'h44);
    step;
    chk("sb_wr4_cnt", bus0.busy_cnt, 64'd1);
    do_wr(1'b1, 5'd2, 32'h22);
    step;
    chk("sb_wr2_cnt", bus0.busy_cnt, 64'd0);
    do_wr(1'b0, 5'd0, 32'h0);

    // Full sweep: allocate all, then retire each with its index.
    for (int a = 1; a < 32; a++) begin
      do_alloc(1'b1, 5'(a));
      step;
      chk("sweep_alloc_cnt", bus0.busy_cnt, 64'(a));
    end
    do_alloc(1'b1, 5'd0);
    step;
    chk("sweep_cap_cnt", bus0.busy_cnt, 64'd31);
    do_alloc(1'b0, 5'd0);
    for (int a = 1; a < 32; a++) begin
      do_wr(1'b1, 5'(a), 32'(a));
      set_rd(5'(a), 5'd0);
      step;
      chk("sweep_wr_cnt", bus0.busy_cnt, 64'(31 - a));
      chk("sweep_wr_u1_byp", bus1.rd_data[31:0], 64'(a));
      chk("sweep_wr_u0_busy", bus0.rd_busy[0], 64'd1);
    end
    do_wr(1'b0, 5'd0, 32'h0);
    for (int a = 1; a < 32; a++) begin
      set_rd(5'(a), 5'(32 - a));
      step;
      chk("sweep_rd_p0", bus0.rd_data[31:0], 64'(a));
      chk("sweep_rd_p1", bus0.rd_data[63:32], 64'(32 - a));
      chk("sweep_rd_busy", bus0.rd_busy, 64'd0);
    end
    chk("sweep_final_cnt", bus0.busy_cnt, 64'd0);
    chk("sweep_final_u1cnt", bus1.busy_cnt, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
